// File: rtl/shift_rotate_unit_pkg.sv
// Shared encodings for the shift/rotate working register: operation modes
// and controller states.
package shift_rotate_unit_pkg;

  // Operation selected by the 2-bit mode input.
  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SHL = 2'b10;
  localparam logic [1:0] MODE_SHR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_rotate_step.sv
// One-position move of a word: rotate left/right or logical shift
// left/right with a caller-supplied fill bit. Purely combinational.
module shift_rotate_step
  import shift_rotate_unit_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  // Select the single-step move for the requested mode.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    result = word;
    case (mode)
      MODE_ROL: result = {word[WIDTH-2:0], word[WIDTH-1]};
      MODE_ROR: result = {word[0], word[WIDTH-1:1]};
      MODE_SHL: result = {word[WIDTH-2:0], fill};
      MODE_SHR: result = {fill, word[WIDTH-1:1]};
      default:  result = word;
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Loadable WIDTH-bit working register that rotates or logically shifts by a
// commanded amount under a start/busy/done handshake. All state changes on
// the falling edge of clock; reset is synchronous and active high.
// Build option SHIFT_ROTATE_UNIT_BARREL_EN: when defined, a command completes
// in a single edge through a chained barrel; otherwise one bit moves per clock.
module shift_rotate_unit
  import shift_rotate_unit_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             fill,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] q_next;
  logic             done_next;

  assign busy = (state == ST_SHIFT);

`ifdef SHIFT_ROTATE_UNIT_BARREL_EN

  // Every representable amount (including values above WIDTH-1 when WIDTH is
  // not a power of two) has its own tap, so no modulo is applied.
  localparam int STEPS = 1 << AMT_W;

  logic [WIDTH-1:0] chain [STEPS];

  assign chain[0] = q;

  for (genvar i = 0; i < STEPS - 1; i++) begin : g_chain
    shift_rotate_step #(.WIDTH(WIDTH)) u_step (
      .word   (chain[i]),
      .mode   (mode),
      .fill   (fill),
      .result (chain[i+1])
    );
  end

  // Next-state logic: load wins, otherwise a start applies the whole move now.
  always_comb begin
    state_next = ST_IDLE;
    q_next     = q;
    done_next  = 1'b0;
    if (load) begin
      q_next = d;
    end else if (start) begin
      q_next    = chain[amount];
      done_next = 1'b1;
    end
  end

  // State and output registers, updated on the falling edge.
  always_ff @(negedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= ST_IDLE;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      done  <= done_next;
    end
  end

`else

  logic [AMT_W-1:0] cnt, cnt_next;
  logic [1:0]       mode_q, mode_next;
  logic             fill_q, fill_next;
  logic [WIDTH-1:0] step_word;

  shift_rotate_step #(.WIDTH(WIDTH)) u_step (
    .word   (q),
    .mode   (mode_q),
    .fill   (fill_q),
    .result (step_word)
  );

  // Next-state logic: accept load/start in IDLE, step once per edge in SHIFT.
  always_comb begin
    state_next = state;
    q_next     = q;
    cnt_next   = cnt;
    mode_next  = mode_q;
    fill_next  = fill_q;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          q_next = d;
        end else if (start) begin
          if (amount == '0) begin
            done_next = 1'b1;
          end else begin
            mode_next  = mode;
            fill_next  = fill;
            cnt_next   = amount;
            state_next = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        // Inputs are deliberately ignored here; only the captured command runs.
        q_next   = step_word;
        cnt_next = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counter, captured command and output registers on the falling edge.
  always_ff @(negedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state  <= ST_IDLE;
      q      <= '0;
      cnt    <= '0;
      mode_q <= MODE_ROL;
      fill_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      q      <= q_next;
      cnt    <= cnt_next;
      mode_q <= mode_next;
      fill_q <= fill_next;
      done   <= done_next;
    end
  end

`endif

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed self-checking bench for shift_rotate_unit (serial build): an
// 8-bit instance for the functional cases and a 128-bit instance for the
// full-width rotate latency case.
module tb_shift_rotate_unit;
  import shift_rotate_unit_pkg::*;

  logic clock = 1'b0;
  logic reset;

  // 8-bit instance signals
  logic       load8, start8, fill8;
  logic [7:0] d8, q8;
  logic [1:0] mode8;
  logic [2:0] amount8;
  logic       busy8, done8;

  // 128-bit instance signals
  logic         load128, start128, fill128;
  logic [127:0] d128, q128;
  logic [1:0]   mode128;
  logic [6:0]   amount128;
  logic         busy128, done128;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  shift_rotate_unit #(.WIDTH(8)) u_dut8 (
    .clock  (clock),
    .reset  (reset),
    .load   (load8),
    .d      (d8),
    .start  (start8),
    .mode   (mode8),
    .amount (amount8),
    .fill   (fill8),
    .q      (q8),
    .busy   (busy8),
    .done   (done8)
  );

  shift_rotate_unit #(.WIDTH(128)) u_dut128 (
    .clock  (clock),
    .reset  (reset),
    .load   (load128),
    .d      (d128),
    .start  (start128),
    .mode   (mode128),
    .amount (amount128),
    .fill   (fill128),
    .q      (q128),
    .busy   (busy128),
    .done   (done128)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance past the next active (falling) edge; outputs are then settled and
  // inputs set afterwards apply at the following edge.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic cmd8(input logic [1:0] m, input logic [2:0] a, input logic f);
    start8  = 1'b1;
    mode8   = m;
    amount8 = a;
    fill8   = f;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    load8 = 0; start8 = 0; fill8 = 0; d8 = '0; mode8 = '0; amount8 = '0;
    load128 = 0; start128 = 0; fill128 = 0; d128 = '0; mode128 = '0; amount128 = '0;
    tick(); tick();
    check("reset_q", q8, 8'h00);
    check("reset_busy", busy8, 1'b0);
    check("reset_done", done8, 1'b0);
    reset = 1'b0;

    // Rotate left 0x81 by 3
    load8 = 1; d8 = 8'h81; tick();
    check("rol_load", q8, 8'h81);
    load8 = 0; cmd8(MODE_ROL, 3'd3, 1'b0); tick();
    check("rol_k_q", q8, 8'h81);
    check("rol_k_busy", busy8, 1'b1);
    start8 = 0; tick();
    check("rol_s1", q8, 8'h03);
    tick();
    check("rol_s2", q8, 8'h06);
    check("rol_s2_busy", busy8, 1'b1);
    tick();
    check("rol_s3", q8, 8'h0C);
    check("rol_done", done8, 1'b1);
    check("rol_busy_end", busy8, 1'b0);
    tick();
    check("rol_done_clear", done8, 1'b0);
    check("rol_hold", q8, 8'h0C);

    // Rotate right by 1, then zero-amount start
    load8 = 1; d8 = 8'h01; tick();
    load8 = 0; cmd8(MODE_ROR, 3'd1, 1'b0); tick();
    check("ror_busy", busy8, 1'b1);
    start8 = 0; tick();
    check("ror_q", q8, 8'h80);
    check("ror_done", done8, 1'b1);
    cmd8(MODE_ROL, 3'd0, 1'b0); tick();
    check("zero_q", q8, 8'h80);
    check("zero_done", done8, 1'b1);
    check("zero_busy", busy8, 1'b0);
    start8 = 0; tick();
    check("zero_done_clear", done8, 1'b0);

    // Logical shifts with fill; back-to-back start on the done cycle;
    // load/start pulses during SHIFT are ignored
    load8 = 1; d8 = 8'hF0; tick();
    load8 = 0; cmd8(MODE_SHR, 3'd2, 1'b1); tick();
    start8 = 0; tick();
    check("shr_s1", q8, 8'hF8);
    tick();
    check("shr_q", q8, 8'hFC);
    check("shr_done", done8, 1'b1);
    cmd8(MODE_SHL, 3'd4, 1'b0); tick();
    check("b2b_busy", busy8, 1'b1);
    check("b2b_q", q8, 8'hFC);
    load8 = 1; d8 = 8'h55; cmd8(MODE_ROR, 3'd1, 1'b1); tick();
    check("ign_s1", q8, 8'hF8);
    load8 = 0; start8 = 0; tick();
    check("ign_s2", q8, 8'hF0);
    tick();
    check("ign_s3", q8, 8'hE0);
    check("ign_no_done", done8, 1'b0);
    tick();
    check("shl_q", q8, 8'hC0);
    check("shl_done", done8, 1'b1);

    // Load wins over a simultaneous start
    load8 = 1; d8 = 8'h3C; cmd8(MODE_ROL, 3'd2, 1'b0); tick();
    check("prio_q", q8, 8'h3C);
    check("prio_busy", busy8, 1'b0);
    check("prio_done", done8, 1'b0);
    load8 = 0; start8 = 0; tick();
    check("prio_hold", q8, 8'h3C);

    // Reset in the middle of a rotate
    load8 = 1; d8 = 8'h81; tick();
    load8 = 0; cmd8(MODE_ROL, 3'd7, 1'b0); tick();
    start8 = 0; tick(); tick(); tick();
    check("mid_s3", q8, 8'h0C);
    reset = 1; tick();
    check("mid_rst_q", q8, 8'h00);
    check("mid_rst_busy", busy8, 1'b0);
    check("mid_rst_done", done8, 1'b0);
    reset = 0; load8 = 1; d8 = 8'h81; tick();
    load8 = 0; cmd8(MODE_ROL, 3'd2, 1'b0); tick();
    start8 = 0; tick(); tick();
    check("post_rst_q", q8, 8'h06);
    check("post_rst_done", done8, 1'b1);

    // 128-bit rotate left by 127: done N+1 = 128 cycles after start
    load128 = 1; d128 = 128'h1; tick();
    load128 = 0; start128 = 1; mode128 = MODE_ROL; amount128 = 7'd127; tick();
    start128 = 0;
    lat = 1;
    while (!done128 && lat < 400) begin
      tick();
      lat++;
    end
    check("w128_latency", lat, 128);
    check("w128_q", q128, {1'b1, 127'b0});
    tick();
    check("w128_done_clear", done128, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
